// File: rtl/wb_bus_arb_if.sv
// rtl/wb_bus_arb_if.sv - Wishbone-classic cyc/ack bus bundle (no stb) shared by masters and slave.
interface wb_bus_arb_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic            cyc;
   logic            we;
   logic [AW-1:0]   adr;
   logic [DW-1:0]   dat;
   logic [DW/8-1:0] sel;
   logic [DW-1:0]   rdt;
   logic            ack;

   modport master (output cyc, we, adr, dat, sel, input rdt, ack);
   modport slave  (input cyc, we, adr, dat, sel, output rdt, ack);
endinterface

// File: rtl/wb_bus_arb.sv
// rtl/wb_bus_arb.sv - Two-master round-robin Wishbone-classic arbiter with transaction lock and bus watchdog.
module wb_bus_arb #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 64
) (
   input  logic               clk,
   input  logic               rst,
   wb_bus_arb_if.slave        a_bus,
   wb_bus_arb_if.slave        b_bus,
   wb_bus_arb_if.master       s_bus,
   output logic [1:0]         grant_o,
   output logic               err_o
);
   localparam int CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int TLIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
   localparam logic [CW-1:0] TLIM_C = CW'(TLIM);

   typedef enum logic [1:0] {IDLE = 2'd0, GNT_A = 2'd1, GNT_B = 2'd2} state_t;

   state_t        state_q, state_d;
   logic          last_b_q, last_b_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
   logic          x_cyc;
   logic          timeout;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         last_b_q <= 1'b1;
         cnt_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         last_b_q <= last_b_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
      end
   end

   // A forced ack only fires for a master still holding cyc; a dropped cyc is an abort.
   always_comb begin
      x_cyc   = 1'b0;
      if (state_q == GNT_A) x_cyc = a_bus.cyc;
      if (state_q == GNT_B) x_cyc = b_bus.cyc;
      timeout = (TIMEOUT > 0) && (state_q != IDLE) && x_cyc && !s_bus.ack && (cnt_q == TLIM_C);
   end

   always_comb begin
      state_d  = state_q;
      last_b_d = last_b_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (a_bus.cyc && (!b_bus.cyc || last_b_q)) state_d = GNT_A;
            else if (b_bus.cyc)                        state_d = GNT_B;
         end
         GNT_A, GNT_B: begin
            if (!x_cyc || s_bus.ack || timeout) begin
               state_d  = IDLE;
               last_b_d = (state_q == GNT_B);
               err_d    = err_q | timeout;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      grant_o   = 2'b00;
      s_bus.cyc = 1'b0;
      s_bus.we  = 1'b0;
      s_bus.adr = '0;
      s_bus.dat = '0;
      s_bus.sel = '0;
      a_bus.ack = 1'b0;
      b_bus.ack = 1'b0;
      a_bus.rdt = s_bus.rdt;
      b_bus.rdt = s_bus.rdt;
      case (state_q)
         GNT_A: begin
            grant_o   = 2'b01;
            s_bus.cyc = a_bus.cyc;
            s_bus.we  = a_bus.we;
            s_bus.adr = a_bus.adr;
            s_bus.dat = a_bus.dat;
            s_bus.sel = a_bus.sel;
            a_bus.ack = s_bus.ack | timeout;
            if (timeout) a_bus.rdt = '1;
         end
         GNT_B: begin
            grant_o   = 2'b10;
            s_bus.cyc = b_bus.cyc;
            s_bus.we  = b_bus.we;
            s_bus.adr = b_bus.adr;
            s_bus.dat = b_bus.dat;
            s_bus.sel = b_bus.sel;
            b_bus.ack = s_bus.ack | timeout;
            if (timeout) b_bus.rdt = '1;
         end
         default: ;
      endcase
   end

   assign err_o = err_q;
endmodule

// File: tb/tb_wb_bus_arb.sv
// tb/tb_wb_bus_arb.sv - Directed and randomized checks of wb_bus_arb against an owner/age bus model.
module tb_wb_bus_arb;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] grant;
   logic       err;
   int         n_tests = 0;
   int         n_fail  = 0;

   always #5 clk = ~clk;

   wb_bus_arb_if #(.AW(AW), .DW(DW)) a_bus ();
   wb_bus_arb_if #(.AW(AW), .DW(DW)) b_bus ();
   wb_bus_arb_if #(.AW(AW), .DW(DW)) s_bus ();

   wb_bus_arb #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
      .clk     (clk),
      .rst     (rst),
      .a_bus   (a_bus),
      .b_bus   (b_bus),
      .s_bus   (s_bus),
      .grant_o (grant),
      .err_o   (err)
   );

   // Model: who owns the slave (0 none, 1 A, 2 B), who owned it last, and how long the owner has waited.
   int          m_owner, m_last, m_age;
   logic        m_err;
   logic        m_cyc, m_to;
   logic [1:0]  e_grant;
   logic [69:0] e_s;
   logic        e_aack, e_back;
   logic [31:0] e_ardt, e_brdt;

   always_comb begin
      m_cyc   = (m_owner == 1) ? a_bus.cyc : (m_owner == 2) ? b_bus.cyc : 1'b0;
      m_to    = (m_owner != 0) && m_cyc && !s_bus.ack && (m_age == TO - 1);
      e_grant = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
      e_s     = '0;
      if (m_owner == 1) e_s = {a_bus.cyc, a_bus.we, a_bus.adr, a_bus.dat, a_bus.sel};
      if (m_owner == 2) e_s = {b_bus.cyc, b_bus.we, b_bus.adr, b_bus.dat, b_bus.sel};
      e_aack  = (m_owner == 1) && (s_bus.ack || m_to);
      e_back  = (m_owner == 2) && (s_bus.ack || m_to);
      e_ardt  = (m_owner == 1 && m_to) ? 32'hFFFF_FFFF : s_bus.rdt;
      e_brdt  = (m_owner == 2 && m_to) ? 32'hFFFF_FFFF : s_bus.rdt;
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_owner <= 0;
         m_last  <= 2;
         m_age   <= 0;
         m_err   <= 1'b0;
      end else if (m_owner == 0) begin
         m_age <= 0;
         if (a_bus.cyc && b_bus.cyc) m_owner <= (m_last == 1) ? 2 : 1;
         else if (a_bus.cyc)         m_owner <= 1;
         else if (b_bus.cyc)         m_owner <= 2;
      end else if (!m_cyc || s_bus.ack || m_to) begin
         m_last  <= m_owner;
         m_owner <= 0;
         if (m_to) m_err <= 1'b1;
      end else begin
         m_age <= m_age + 1;
      end
   end

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         chk("grant", 72'(grant), 72'(e_grant));
         chk("slave_side", 72'({s_bus.cyc, s_bus.we, s_bus.adr, s_bus.dat, s_bus.sel}), 72'(e_s));
         chk("a_ack", 72'(a_bus.ack), 72'(e_aack));
         chk("b_ack", 72'(b_bus.ack), 72'(e_back));
         chk("a_rdt", 72'(a_bus.rdt), 72'(e_ardt));
         chk("b_rdt", 72'(b_bus.rdt), 72'(e_brdt));
         chk("err", 72'(err), 72'(m_err));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      a_bus.cyc = 0; a_bus.we = 0; a_bus.adr = '0; a_bus.dat = '0; a_bus.sel = '0;
      b_bus.cyc = 0; b_bus.we = 0; b_bus.adr = '0; b_bus.dat = '0; b_bus.sel = '0;
      s_bus.ack = 0; s_bus.rdt = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_inputs();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   logic [1:0] exp_seq [5];
   logic       ack_a, ack_b, ab_a, ab_b, s_busy;
   logic [1:0] g;
   int         s_wait;

   initial begin
      clear_inputs();
      do_reset();
      chk("reset_grant", 72'(grant), 72'(2'b00));
      chk("reset_s_cyc", 72'(s_bus.cyc), 72'(1'b0));
      chk("reset_err", 72'(err), 72'(1'b0));

      // Solo A read, slave acks on the third grant cycle.
      a_bus.cyc = 1; a_bus.adr = 32'h100;
      tick(); chk("solo_g1", 72'(grant), 72'(2'b01)); chk("solo_adr", 72'(s_bus.adr), 72'(32'h100));
      chk("model_g1", 72'(e_grant), 72'(2'b01));
      tick(); chk("solo_g2", 72'(grant), 72'(2'b01)); chk("solo_ack_early", 72'(a_bus.ack), 72'(1'b0));
      tick(); s_bus.ack = 1; s_bus.rdt = 32'h1234_5678; #1;
      chk("solo_g3", 72'(grant), 72'(2'b01)); chk("solo_ack", 72'(a_bus.ack), 72'(1'b1));
      chk("solo_rdt", 72'(a_bus.rdt), 72'(32'h1234_5678)); chk("solo_b_ack", 72'(b_bus.ack), 72'(1'b0));
      tick(); a_bus.cyc = 0; s_bus.ack = 0; #1;
      chk("solo_idle", 72'(grant), 72'(2'b00));

      // Both masters always requesting: grants alternate with one idle cycle between.
      do_reset();
      exp_seq = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
      a_bus.cyc = 1; b_bus.cyc = 1;
      for (int i = 0; i < 5; i++) begin
         tick(); s_bus.ack = 0; #1;
         chk("alt_grant", 72'(grant), 72'(exp_seq[i]));
         s_bus.ack = (grant != 2'b00);
      end
      tick(); clear_inputs();

      // B write passthrough.
      do_reset();
      b_bus.cyc = 1; b_bus.we = 1; b_bus.adr = 32'h2000_0004; b_bus.dat = 32'hCAFE_F00D; b_bus.sel = 4'b0011;
      tick();
      chk("wr_grant", 72'(grant), 72'(2'b10));
      chk("wr_slave", 72'({s_bus.cyc, s_bus.we, s_bus.adr, s_bus.dat, s_bus.sel}),
          72'({1'b1, 1'b1, 32'h2000_0004, 32'hCAFE_F00D, 4'b0011}));
      s_bus.ack = 1; #1;
      chk("wr_ack", 72'(b_bus.ack), 72'(1'b1));
      tick(); clear_inputs();

      // Watchdog: slave never acks A; B waits, then is served normally.
      do_reset();
      a_bus.cyc = 1; b_bus.cyc = 1; b_bus.adr = 32'h40;
      for (int i = 1; i <= TO; i++) begin
         tick();
         chk("to_grant", 72'(grant), 72'(2'b01));
         chk("to_ack", 72'(a_bus.ack), 72'(i == TO));
      end
      chk("to_rdt", 72'(a_bus.rdt), 72'(32'hFFFF_FFFF));
      chk("to_s_cyc", 72'(s_bus.cyc), 72'(1'b1));
      chk("to_err_pre", 72'(err), 72'(1'b0));
      tick(); a_bus.cyc = 0; #1;
      chk("to_idle", 72'(grant), 72'(2'b00)); chk("to_err", 72'(err), 72'(1'b1));
      tick(); chk("to_b_grant", 72'(grant), 72'(2'b10));
      s_bus.ack = 1; s_bus.rdt = 32'h0BAD_BEEF; #1;
      chk("to_b_ack", 72'(b_bus.ack), 72'(1'b1)); chk("to_b_rdt", 72'(b_bus.rdt), 72'(32'h0BAD_BEEF));
      tick(); b_bus.cyc = 0; s_bus.ack = 0; #1;
      chk("to_err_sticky", 72'(err), 72'(1'b1));

      // Asynchronous reset mid-GNT_A clears everything, including the sticky err.
      a_bus.cyc = 1;
      tick(); chk("rst_pre_grant", 72'(grant), 72'(2'b01));
      rst = 1; #1;
      chk("rst_s_cyc", 72'(s_bus.cyc), 72'(1'b0)); chk("rst_grant", 72'(grant), 72'(2'b00));
      chk("rst_err", 72'(err), 72'(1'b0)); chk("rst_a_ack", 72'(a_bus.ack), 72'(1'b0));

      // A aborts with B pending; a late ack in IDLE reaches nobody.
      do_reset();
      a_bus.cyc = 1; b_bus.cyc = 1;
      tick(); chk("ab_grant_a", 72'(grant), 72'(2'b01)); a_bus.cyc = 0;
      tick(); chk("ab_idle", 72'(grant), 72'(2'b00));
      s_bus.ack = 1; #1;
      chk("ab_late_a", 72'(a_bus.ack), 72'(1'b0)); chk("ab_late_b", 72'(b_bus.ack), 72'(1'b0));
      tick(); s_bus.ack = 0; #1;
      chk("ab_grant_b", 72'(grant), 72'(2'b10)); chk("ab_b_noack", 72'(b_bus.ack), 72'(1'b0));
      s_bus.ack = 1; #1;
      chk("ab_b_ack", 72'(b_bus.ack), 72'(1'b1));
      tick(); clear_inputs();

      // Randomized traffic, checked every cycle by the model.
      do_reset();
      s_busy = 0; s_wait = 0;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         ack_a = a_bus.ack; ack_b = b_bus.ack; g = grant;
         @(posedge clk); #1;
         ab_a = a_bus.cyc && !ack_a && (g == 2'b01) && ($urandom_range(99) < 4);
         ab_b = b_bus.cyc && !ack_b && (g == 2'b10) && ($urandom_range(99) < 4);
         if (ack_a || ab_a) a_bus.cyc = 0;
         if (ack_b || ab_b) b_bus.cyc = 0;
         if (!a_bus.cyc && !ab_a && $urandom_range(99) < 40) begin
            a_bus.cyc = 1; a_bus.we = 1'($urandom_range(1)); a_bus.adr = $urandom;
            a_bus.dat = $urandom; a_bus.sel = 4'($urandom_range(15));
         end
         if (!b_bus.cyc && !ab_b && $urandom_range(99) < 40) begin
            b_bus.cyc = 1; b_bus.we = 1'($urandom_range(1)); b_bus.adr = $urandom;
            b_bus.dat = $urandom; b_bus.sel = 4'($urandom_range(15));
         end
         #1;
         if (s_bus.cyc) begin
            if (!s_busy) begin
               s_busy = 1;
               s_wait = ($urandom_range(9) == 0) ? 12 : int'($urandom_range(3));
            end
            if (s_wait == 0) begin
               s_bus.ack = 1; s_bus.rdt = $urandom; s_busy = 0;
            end else begin
               s_bus.ack = 0; s_wait--;
            end
         end else begin
            s_busy = 0;
            s_bus.ack = (grant == 2'b00) && ($urandom_range(9) == 0);
            s_bus.rdt = $urandom;
         end
      end

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
